// File: rtl/timer_host_master_pkg.sv
// rtl/timer_host_master_pkg.sv - register map, control bits and FSM states for the timer host master
package timer_host_pkg;

    // Halfword register indices of the interval timer slave
    localparam logic [3:0] REG_STATUS  = 4'd0;
    localparam logic [3:0] REG_CONTROL = 4'd1;
    localparam logic [3:0] REG_PERIOD0 = 4'd2;
    localparam logic [3:0] REG_PERIOD1 = 4'd3;
    localparam logic [3:0] REG_PERIOD2 = 4'd4;
    localparam logic [3:0] REG_PERIOD3 = 4'd5;
    localparam logic [3:0] REG_SNAP0   = 4'd6;
    localparam logic [3:0] REG_SNAP1   = 4'd7;
    localparam logic [3:0] REG_SNAP2   = 4'd8;
    localparam logic [3:0] REG_SNAP3   = 4'd9;

    // Control register bit positions
    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_PER,
        ST_WR_CTRL,
        ST_RUN,
        ST_CLR_TO,
        ST_SNAP_WR,
        ST_SNAP_RD,
        ST_STOP_WR
    } state_e;

endpackage

// File: rtl/timer_host_master_if.sv
// rtl/timer_host_master_if.sv - Avalon-MM bus between the timer host master and the timer slave
interface timer_host_master_if;
    logic [3:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [15:0] m_writedata;
    logic [15:0] m_readdata;
    logic        irq;

    modport master (
        output m_address, m_chipselect, m_write_n, m_writedata,
        input  m_readdata, irq
    );

    modport slave (
        input  m_address, m_chipselect, m_write_n, m_writedata,
        output m_readdata, irq
    );
endinterface

// File: rtl/timer_host_master.sv
// rtl/timer_host_master.sv - Avalon-MM initiator that programs and services the interval timer
module timer_host_master
    import timer_host_pkg::*;
#(
    parameter int TICK_CNT_W = 32,
    parameter bit CONTINUOUS = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  snap_req,
    input  logic [63:0]           period_i,
    output logic                  busy,
    output logic                  running,
    output logic                  tick,
    output logic [TICK_CNT_W-1:0] tick_count,
    output logic [63:0]           snapshot,
    output logic                  snap_valid,
    timer_host_master_if.master   bus
);

    localparam logic [15:0] CTRL_GO   = 16'((1 << CTRL_ITO) | (1 << CTRL_START) |
                                            (int'(CONTINUOUS) << CTRL_CONT));
    localparam logic [15:0] CTRL_HALT = 16'(1 << CTRL_STOP);

    state_e                state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic                  phase_q, phase_d;
    logic                  ret_run_q, ret_run_d;
    logic                  start_pend_q, start_pend_d;
    logic                  stop_pend_q, stop_pend_d;
    logic                  snap_pend_q, snap_pend_d;
    logic [63:0]           per_pend_q, per_pend_d;
    logic [63:0]           period_q, period_d;
    logic                  running_q, running_d;
    logic                  tick_q, tick_d;
    logic [TICK_CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [47:0]           snap_buf_q, snap_buf_d;
    logic [63:0]           snapshot_q, snapshot_d;
    logic                  snap_valid_q, snap_valid_d;

    logic take_start, take_stop, take_snap;
    logic start_req, stop_req, snap_req_any;

    assign start_req    = start | start_pend_q;
    assign stop_req     = stop | stop_pend_q;
    assign snap_req_any = snap_req | snap_pend_q;

    // State and datapath registers; reset aborts to IDLE and idles the bus
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= 2'd0;
            phase_q      <= 1'b0;
            ret_run_q    <= 1'b0;
            start_pend_q <= 1'b0;
            stop_pend_q  <= 1'b0;
            snap_pend_q  <= 1'b0;
            per_pend_q   <= 64'd0;
            period_q     <= 64'd0;
            running_q    <= 1'b0;
            tick_q       <= 1'b0;
            tick_cnt_q   <= '0;
            snap_buf_q   <= 48'd0;
            snapshot_q   <= 64'd0;
            snap_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            phase_q      <= phase_d;
            ret_run_q    <= ret_run_d;
            start_pend_q <= start_pend_d;
            stop_pend_q  <= stop_pend_d;
            snap_pend_q  <= snap_pend_d;
            per_pend_q   <= per_pend_d;
            period_q     <= period_d;
            running_q    <= running_d;
            tick_q       <= tick_d;
            tick_cnt_q   <= tick_cnt_d;
            snap_buf_q   <= snap_buf_d;
            snapshot_q   <= snapshot_d;
            snap_valid_q <= snap_valid_d;
        end
    end

    // Next state: request arbitration in IDLE/RUN (stop > irq > snap > start), access sequencing elsewhere
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        phase_d    = phase_q;
        ret_run_d  = ret_run_q;
        take_start = 1'b0;
        take_stop  = 1'b0;
        take_snap  = 1'b0;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (stop_req) begin
                    take_stop = 1'b1;
                    state_d   = ST_STOP_WR;
                end else if (state_q == ST_RUN && bus.irq) begin
                    state_d = ST_CLR_TO;
                end else if (snap_req_any) begin
                    take_snap = 1'b1;
                    ret_run_d = (state_q == ST_RUN);
                    state_d   = ST_SNAP_WR;
                end else if (start_req) begin
                    take_start = 1'b1;
                    idx_d      = 2'd0;
                    state_d    = ST_WR_PER;
                end
            end
            ST_WR_PER: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) state_d = ST_WR_CTRL;
            end
            ST_WR_CTRL: state_d = ST_RUN;
            ST_CLR_TO:  state_d = CONTINUOUS ? ST_RUN : ST_IDLE;
            ST_SNAP_WR: begin
                idx_d   = 2'd0;
                phase_d = 1'b0;
                state_d = ST_SNAP_RD;
            end
            ST_SNAP_RD: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    idx_d   = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = ret_run_q ? ST_RUN : ST_IDLE;
                end
            end
            ST_STOP_WR: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Datapath: pending requests, period latch, running flag, tick count and snapshot assembly
    always_comb begin
        start_pend_d = (start_pend_q | start) & ~take_start;
        stop_pend_d  = (stop_pend_q | stop) & ~take_stop;
        snap_pend_d  = (snap_pend_q | snap_req) & ~take_snap;

        // A repeated start while one is pending keeps the first period
        per_pend_d = per_pend_q;
        if (start && !start_pend_q) per_pend_d = period_i;
        period_d = period_q;
        if (take_start) period_d = start_pend_q ? per_pend_q : period_i;

        running_d = running_q;
        case (state_q)
            ST_WR_CTRL: running_d = 1'b1;
            ST_STOP_WR: running_d = 1'b0;
            ST_CLR_TO:  if (!CONTINUOUS) running_d = 1'b0;
            default:    running_d = running_q;
        endcase

        tick_d     = (state_q == ST_CLR_TO);
        tick_cnt_d = tick_cnt_q;
        if (tick_d) tick_cnt_d = tick_cnt_q + TICK_CNT_W'(1);

        // Halfwords collect in a buffer so snapshot only changes once, complete
        snap_buf_d   = snap_buf_q;
        snapshot_d   = snapshot_q;
        snap_valid_d = 1'b0;
        if (state_q == ST_SNAP_RD && phase_q) begin
            case (idx_q)
                2'd0:    snap_buf_d[15:0]  = bus.m_readdata;
                2'd1:    snap_buf_d[31:16] = bus.m_readdata;
                2'd2:    snap_buf_d[47:32] = bus.m_readdata;
                default: begin
                    snapshot_d   = {bus.m_readdata, snap_buf_q};
                    snap_valid_d = 1'b1;
                end
            endcase
        end
    end

    // Bus drive and status outputs decoded from the current state
    always_comb begin
        bus.m_chipselect = 1'b0;
        bus.m_write_n    = 1'b1;
        bus.m_address    = REG_STATUS;
        bus.m_writedata  = 16'd0;
        case (state_q)
            ST_WR_PER: begin
                bus.m_chipselect = 1'b1;
                bus.m_write_n    = 1'b0;
                bus.m_address    = REG_PERIOD0 + {2'b00, idx_q};
                bus.m_writedata  = period_q[{idx_q, 4'b0000} +: 16];
            end
            ST_WR_CTRL: begin
                bus.m_chipselect = 1'b1;
                bus.m_write_n    = 1'b0;
                bus.m_address    = REG_CONTROL;
                bus.m_writedata  = CTRL_GO;
            end
            ST_CLR_TO: begin
                bus.m_chipselect = 1'b1;
                bus.m_write_n    = 1'b0;
                bus.m_address    = REG_STATUS;
            end
            ST_SNAP_WR: begin
                bus.m_chipselect = 1'b1;
                bus.m_write_n    = 1'b0;
                bus.m_address    = REG_SNAP0;
            end
            ST_SNAP_RD: begin
                // Strobe only in the issue cycle; address held through capture
                bus.m_chipselect = ~phase_q;
                bus.m_address    = REG_SNAP0 + {2'b00, idx_q};
            end
            ST_STOP_WR: begin
                bus.m_chipselect = 1'b1;
                bus.m_write_n    = 1'b0;
                bus.m_address    = REG_CONTROL;
                bus.m_writedata  = CTRL_HALT;
            end
            default: bus.m_chipselect = 1'b0;
        endcase
        busy       = (state_q != ST_IDLE) && (state_q != ST_RUN);
        running    = running_q;
        tick       = tick_q;
        tick_count = tick_cnt_q;
        snapshot   = snapshot_q;
        snap_valid = snap_valid_q;
    end

endmodule
